// File: rtl/mem_stage_bus_controller.sv
// mem_stage_bus_controller: MEM-stage load/store sequencer driving a req/ack data bus
// Ports:
//   i_clock, i_reset                       clock, async active-high reset
//   i_isValid, i_memRead, i_memWrite       EXMEM op qualifiers
//   i_access, i_unsigned, i_addr, i_wrData held EXMEM access description
//   o_hazard                               MEM hazard to stall control (combinational)
//   o_done, o_fault, o_rdData              retire pulse, fault flag, extended load data
//   o_bus_*, i_bus_*                       request/acknowledge data bus
module mem_stage_bus_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_isValid,
    input  logic                  i_memRead,
    input  logic                  i_memWrite,
    input  logic [1:0]            i_access,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wrData,
    output logic                  o_hazard,
    output logic                  o_done,
    output logic                  o_fault,
    output logic [31:0]           o_rdData,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [3:0]            o_bus_be,
    output logic [31:0]           o_bus_wdata,
    input  logic                  i_bus_ack,
    input  logic                  i_bus_rvalid,
    input  logic [31:0]           i_bus_rdata
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Abort in the cycle the counter would reach TIMEOUT_CYCLES, so REQ+WAIT lasts exactly that long
    localparam logic [CW-1:0] TO_LIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_fault;
    logic [31:0]   r_rdData;
    logic          w_memOp, w_aligned, w_timeout, w_abort, w_req;
    logic [3:0]    w_be;
    logic [31:0]   w_shifted, w_ext;

    assign w_memOp   = i_isValid & (i_memRead | i_memWrite);
    assign w_aligned = (i_access == 2'b00) ? 1'b1 :
                       (i_access == 2'b01) ? ~i_addr[0] : (i_addr[1:0] == 2'b00);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt >= TO_LIM);
    // Ack/rvalid win over a coincident timeout: the bus did complete the access
    assign w_abort   = w_timeout & (((r_state == REQ) & ~i_bus_ack) | ((r_state == WAIT) & ~i_bus_rvalid));
    assign w_req     = (r_state == REQ);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_memOp) w_next = w_aligned ? REQ : DONE;
            REQ:  if (i_bus_ack) w_next = i_memWrite ? DONE : WAIT;
                  else if (w_timeout) w_next = DONE;
            WAIT: if (i_bus_rvalid || w_timeout) w_next = DONE;
            DONE: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_fault  <= 1'b0;
            r_rdData <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == REQ || r_state == WAIT) ? r_cnt + CW'(1) : '0;
            if (r_state == IDLE && w_memOp) r_fault <= ~w_aligned;
            else if (w_abort) r_fault <= 1'b1;
            if (r_state == WAIT && i_bus_rvalid) r_rdData <= w_ext;
        end
    end

    assign w_shifted = i_bus_rdata >> {i_addr[1:0], 3'b000};
    assign w_ext     = (i_access == 2'b00) ? {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]} :
                       (i_access == 2'b01) ? {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]} :
                       w_shifted;
    assign w_be      = (i_access == 2'b00) ? 4'b0001 << i_addr[1:0] :
                       (i_access == 2'b01) ? 4'b0011 << i_addr[1:0] : 4'b1111;

    // Reset gates the hazard so every output reads 0 while reset is held
    assign o_hazard    = w_memOp & (r_state != DONE) & ~i_reset;
    assign o_done      = (r_state == DONE);
    assign o_fault     = (r_state == DONE) & r_fault;
    assign o_rdData    = r_rdData;
    assign o_bus_req   = w_req;
    assign o_bus_we    = w_req & i_memWrite;
    assign o_bus_addr  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
    assign o_bus_be    = w_req ? w_be : 4'b0000;
    assign o_bus_wdata = (i_access == 2'b00) ? {4{i_wrData[7:0]}} :
                         (i_access == 2'b01) ? {2{i_wrData[15:0]}} : i_wrData;
endmodule

// File: tb/tb_mem_stage_bus_controller.sv
// tb_mem_stage_bus_controller: table-driven and directed checks of the MEM bus sequencer
module tb_mem_stage_bus_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid, mrd, mwr, uns, ack, rvalid;
    logic [1:0]  acc;
    logic [31:0] addr, wdat, rdata;
    logic        o_hazard, o_done, o_fault, o_bus_req, o_bus_we;
    logic [31:0] o_rdData, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_stage_bus_controller #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_isValid(valid), .i_memRead(mrd), .i_memWrite(mwr),
        .i_access(acc), .i_unsigned(uns), .i_addr(addr), .i_wrData(wdat),
        .o_hazard(o_hazard), .o_done(o_done), .o_fault(o_fault), .o_rdData(o_rdData),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
        .o_bus_wdata(o_bus_wdata), .i_bus_ack(ack), .i_bus_rvalid(rvalid), .i_bus_rdata(rdata)
    );

    typedef struct {
        logic        rd, wr;
        logic [1:0]  acc;
        logic        uns;
        logic [31:0] addr, wdata, rdata;
        int          ack_dly, rv_dly;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_done;
        logic        e_fault;
        logic [31:0] e_rd;
        int          e_req;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Presents one op from cycle 0, acks on the ack_dly-th REQ cycle, raises rvalid rv_dly cycles later
    task automatic run_op(input vec_t v, input string nm);
        int n, req_n, ack_at, done_at, haz_n;
        logic        flt, we;
        logic [3:0]  be;
        logic [31:0] wd, rd, ba;
        req_n = 0; ack_at = -1; done_at = -1; haz_n = 0;
        flt = 0; we = 0; be = 0; wd = 0; rd = 0; ba = 0;
        for (n = 0; n < 20 && done_at < 0; n++) begin
            @(negedge clk);
            valid = 1; mrd = v.rd; mwr = v.wr; acc = v.acc; uns = v.uns;
            addr = v.addr; wdat = v.wdata; rdata = v.rdata; ack = 0; rvalid = 0;
            #1;
            if (o_hazard) haz_n++;
            if (o_bus_req) begin
                be = o_bus_be; wd = o_bus_wdata; we = o_bus_we; ba = o_bus_addr;
                if (req_n == v.ack_dly) begin
                    ack = 1;
                    ack_at = n;
                end
                req_n++;
            end
            if (v.rd && ack_at >= 0 && n == ack_at + v.rv_dly) rvalid = 1;
            if (o_done) begin
                done_at = n;
                flt = o_fault;
                rd = o_rdData;
            end
        end
        chk({nm, "_done_cycle"}, 64'(done_at), 64'(v.e_done));
        chk({nm, "_fault"}, 64'(flt), 64'(v.e_fault));
        chk({nm, "_hazard_cycles"}, 64'(haz_n), 64'(v.e_done));
        chk({nm, "_req_cycles"}, 64'(req_n), 64'(v.e_req));
        if (v.e_req > 0) begin
            chk({nm, "_be"}, 64'(be), 64'(v.e_be));
            chk({nm, "_we"}, 64'(we), 64'(v.wr));
            chk({nm, "_addr"}, 64'(ba), 64'({v.addr[31:2], 2'b00}));
        end
        if (v.wr && v.e_req > 0) chk({nm, "_wdata"}, 64'(wd), 64'(v.e_wdata));
        if (v.rd && !v.e_fault) chk({nm, "_rdata"}, 64'(rd), 64'(v.e_rd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        rd wr acc uns addr        wdata         rdata         ack rv be       e_wdata       done flt e_rd          req
        tv[0]  = '{0, 1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0,  0, 4'b1111, 32'hDEADBEEF, 2, 0, 32'h0,        1};
        tv[1]  = '{1, 0, 0, 0, 32'h103, 32'h0,        32'h80FF1234, 0,  3, 4'b1000, 32'h0,        5, 0, 32'hFFFFFF80, 1};
        tv[2]  = '{1, 0, 0, 1, 32'h103, 32'h0,        32'h80FF1234, 0,  3, 4'b1000, 32'h0,        5, 0, 32'h00000080, 1};
        tv[3]  = '{0, 1, 1, 0, 32'h102, 32'h0000ABCD, 32'h0,        0,  0, 4'b1100, 32'hABCDABCD, 2, 0, 32'h0,        1};
        tv[4]  = '{1, 0, 2, 0, 32'h102, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        1, 1, 32'h0,        0};
        tv[5]  = '{1, 0, 2, 0, 32'h104, 32'h0,        32'h12345678, 1,  1, 4'b1111, 32'h0,        4, 0, 32'h12345678, 2};
        tv[6]  = '{1, 0, 1, 0, 32'h102, 32'h0,        32'h80010000, 0,  1, 4'b1100, 32'h0,        3, 0, 32'hFFFF8001, 1};
        tv[7]  = '{1, 0, 1, 1, 32'h106, 32'h0,        32'h9ABC0000, 0,  1, 4'b1100, 32'h0,        3, 0, 32'h00009ABC, 1};
        tv[8]  = '{0, 1, 0, 0, 32'h101, 32'h123456A5, 32'h0,        0,  0, 4'b0010, 32'hA5A5A5A5, 2, 0, 32'h0,        1};
        tv[9]  = '{1, 0, 3, 0, 32'h108, 32'h0,        32'hCAFEF00D, 0,  1, 4'b1111, 32'h0,        3, 0, 32'hCAFEF00D, 1};
        tv[10] = '{0, 1, 1, 0, 32'h101, 32'h00001234, 32'h0,        0,  0, 4'b0000, 32'h0,        1, 1, 32'h0,        0};
        tv[11] = '{1, 0, 0, 0, 32'h101, 32'h0,        32'h00007F00, 0,  1, 4'b0010, 32'h0,        3, 0, 32'h0000007F, 1};
        tv[12] = '{1, 0, 2, 0, 32'h10C, 32'h0,        32'h0,        99, 0, 4'b1111, 32'h0,        5, 1, 32'h0,        4};
        tv[13] = '{1, 0, 2, 0, 32'h110, 32'h0,        32'hFFFFFFFF, 0,  0, 4'b1111, 32'h0,        5, 1, 32'h0,        1};

        valid = 1; mrd = 1; mwr = 0; acc = 2; uns = 0; addr = 32'h200; wdat = 0;
        ack = 0; rvalid = 0; rdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs", 64'({o_hazard, o_done, o_fault, o_bus_req, o_bus_we, o_bus_be, o_rdData}), 64'h0);
        valid = 0;
        rst = 0;
        @(negedge clk);
        #1 chk("idle_outputs", 64'({o_hazard, o_done, o_bus_req, o_bus_be}), 64'h0);

        for (int i = 0; i < 14; i++) run_op(tv[i], $sformatf("v%0d", i));

        // Late responses after a timeout must not disturb the last captured load data
        repeat (2) begin
            @(negedge clk);
            valid = 0; mrd = 0; ack = 1; rvalid = 1; rdata = 32'hFFFFFFFF;
            #1;
            chk("late_rv_rdata", 64'(o_rdData), 64'h7F);
            chk("late_rv_quiet", 64'({o_done, o_bus_req, o_hazard}), 64'h0);
        end

        run_op(tv[0], "b2b_sw");
        run_op(tv[9], "b2b_lw");
        repeat (3) begin
            @(negedge clk);
            valid = 1; mrd = 0; mwr = 0; ack = 0; rvalid = 0;
            #1 chk("b2b_add_quiet", 64'({o_hazard, o_bus_req, o_done, o_bus_be}), 64'h0);
        end

        @(negedge clk);
        valid = 1; mrd = 1; mwr = 0; acc = 2; uns = 0; addr = 32'h200; rdata = 32'h55AA55AA;
        #1 chk("rstw_idle_hazard", 64'(o_hazard), 64'h1);
        @(negedge clk);
        ack = 1;
        #1 chk("rstw_req", 64'(o_bus_req), 64'h1);
        @(negedge clk);
        ack = 0;
        #1 chk("rstw_wait_hazard", 64'({o_hazard, o_bus_req, o_done}), 64'b100);
        #2 rst = 1;
        #1 chk("rstw_outputs", 64'({o_hazard, o_done, o_fault, o_bus_req, o_bus_we, o_bus_be, o_rdData}), 64'h0);
        @(negedge clk);
        valid = 0;
        rst = 0;
        run_op(tv[5], "post_rst_lw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_bus_controller.md
Name: mem_stage_bus_controller

Overview:
Data-memory access sequencer for the MEM stage of the RV32 pipeline. It is the producer side of the MEM hazard line consumed by the pipeline stall control. It turns the load/store held in EXMEM into a request/acknowledge bus transaction, holds the MEM hazard until the access completes, and returns aligned, extended load data to MEMWB. It also flags misaligned accesses and bus timeouts.

Parameters:
ADDR_WIDTH, 32, width of address ports.
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before abort; 0 disables timeout. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
i_clock  in  1  clock, rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_isValid  in  1  EXMEM holds a valid instruction.
i_memRead  in  1  instruction is a load.
i_memWrite  in  1  instruction is a store (i_memRead and i_memWrite are never both set).
i_access  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
i_unsigned  in  1  zero-extend load (LBU/LHU).
i_addr  in  ADDR_WIDTH  byte address.
i_wrData  in  32  store data, right-aligned.
o_hazard  out  1  to stall control MEM hazard input; combinational.
o_done  out  1  one-cycle pulse, memory op retires this cycle.
o_fault  out  1  valid with o_done: misaligned or timeout.
o_rdData  out  32  extended load data, valid when o_done && load && !o_fault.
o_bus_req  out  1  bus request.
o_bus_we  out  1  write strobe.
o_bus_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits = 0).
o_bus_be  out  4  byte enables.
o_bus_wdata  out  32  lane-replicated store data.
i_bus_ack  in  1  request accepted (write complete if o_bus_we).
i_bus_rvalid  in  1  read data valid.
i_bus_rdata  in  32  read data.

Behaviour:
- memOp = i_isValid & (i_memRead | i_memWrite). A non-memory or invalid instruction never raises hazard, never touches the bus, and o_done stays 0.
- FSM states IDLE, REQ, WAIT, DONE. Reset state is IDLE.
  - IDLE: if memOp & aligned, go to REQ. If memOp & misaligned, go to DONE with the fault flag set.
  - REQ: if i_bus_ack and store, go to DONE. If i_bus_ack and load, go to WAIT.
  - WAIT: on i_bus_rvalid, capture extended data and go to DONE.
  - DONE: unconditionally go to IDLE.
- o_hazard = memOp & (state != DONE). The hazard is therefore asserted in the first IDLE cycle of an op, with no lost cycle. It drops in DONE so EXMEM advances.
- o_done = (state == DONE). o_fault = (state == DONE) & faultReg. faultReg is cleared on entry to REQ.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00. Byte is always aligned.
- o_bus_req = (state == REQ). o_bus_addr, o_bus_be, o_bus_we and o_bus_wdata are driven combinationally from the held EXMEM inputs, which are stable because EXMEM is stalled. They must be stable while o_bus_req is high.
- Byte enables:
  - byte: 0001 << addr[1:0].
  - half: 0011 << addr[1:0].
  - word: 1111.
  - o_bus_be is 0 when not in REQ.
- Write data replication:
  - byte: replicated to all 4 lanes.
  - half: replicated to both halves.
  - word: as is.
- Load data: shift i_bus_rdata right by 8*addr[1:0], then sign- or zero-extend per i_access/i_unsigned. o_rdData is registered at capture and held until the next capture. Reset value is 0.
- Minimum latency, counted from the cycle an op first appears in EXMEM to o_done:
  - store with immediate ack: 2 cycles (IDLE, REQ, DONE on cycle 2).
  - load with ack and rvalid in the next cycle: 3 cycles.
- i_bus_rvalid in the same cycle as the ack is not captured; rvalid is sampled only in WAIT.
- Timeout: the counter resets on entry to REQ and increments in REQ/WAIT. When it reaches TIMEOUT_CYCLES, go to DONE with the fault flag set and drop o_bus_req. A late ack or rvalid arriving in IDLE/DONE is ignored.
- i_isValid falling mid-transaction does not occur by construction, because EXMEM is stalled. If it does occur, the FSM still completes the bus transaction and does not abort.
- Reset mid-op: asynchronous return to IDLE. All outputs go to 0: o_hazard, o_done, o_fault, o_bus_req, o_bus_we, o_bus_be, o_rdData. The counter is cleared.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, ack on first REQ cycle -> be=1111, wdata=0xDEADBEEF, o_hazard high 2 cycles, o_done on cycle 2, fault 0.
2. LB addr 0x103 with rdata 0x80FF_1234, rvalid 3 cycles after ack -> o_rdData=0xFFFFFF80. LBU of the same data -> 0x00000080. Hazard holds through WAIT.
3. SH to addr 0x102 with data 0x0000ABCD -> be=1100, wdata=0xABCDABCD. LW to addr 0x102 -> no bus request, o_done and o_fault in the cycle after presentation.
4. TIMEOUT_CYCLES=4, LW with ack withheld -> o_bus_req high 4 cycles then drops, o_done+o_fault. A later rvalid has no effect on o_rdData.
5. Back-to-back SW, LW, ADD with all acks immediate -> each memory op yields exactly one o_done. The ADD raises no hazard and no request.
6. Reset asserted while in WAIT -> all outputs 0 asynchronously. After release, the next LW runs normally to completion.
